// File: rtl/custcounter_pkg.sv
// Shared constants and state type for the custom +5/-2 counter generator and checker.
package custcounter_pkg;

  localparam int unsigned CC_WIDTH = 8;
  localparam int unsigned CC_INC   = 5;
  localparam int unsigned CC_DEC   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOCKED
  } chk_state_t;

endpackage

// File: rtl/cc_step_predict.sv
// Combinational step helper: predicts the next count from prev/phase and classifies
// the observed difference as a +INC or -DEC step.
module cc_step_predict
  import custcounter_pkg::*;
#(
  parameter int unsigned WIDTH = CC_WIDTH,
  parameter int unsigned INC   = CC_INC,
  parameter int unsigned DEC   = CC_DEC
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic             i_next_add,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_pred,
  output logic             o_is_inc,
  output logic             o_is_dec
);

  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_diff   = i_sample - i_prev;
    o_pred   = i_next_add ? (i_prev + WIDTH'(INC)) : (i_prev - WIDTH'(DEC));
    o_is_inc = (w_diff == WIDTH'(INC));
    // -DEC modulo 2**WIDTH
    o_is_dec = (w_diff == (WIDTH'(0) - WIDTH'(DEC)));
  end

endmodule

// File: rtl/custcounter_checker.sv
// Receive-side checker: locks to the +INC/-DEC phase of a count stream, predicts each
// next sample, pulses o_err on mismatches and drops lock after MISS_LIMIT misses in a row.
module custcounter_checker
  import custcounter_pkg::*;
#(
  parameter int unsigned WIDTH      = CC_WIDTH,
  parameter int unsigned INC        = CC_INC,
  parameter int unsigned DEC        = CC_DEC,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_locked,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_next_add,
  output logic             o_err,
  output logic [7:0]       o_err_count
);

  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  // A +INC step indistinguishable from a -DEC step would make phase lock ambiguous.
  if (INC == (2 ** WIDTH) - DEC) begin : g_bad_steps
    $error("custcounter_checker: INC must differ from 2**WIDTH-DEC");
  end

  chk_state_t        r_state, w_state_d;
  logic [WIDTH-1:0]  r_prev, w_prev_d;
  logic [MISS_W-1:0] r_miss_run, w_miss_d;
  logic              r_next_add, w_next_add_d;
  logic              r_locked, w_locked_d;
  logic [WIDTH-1:0]  r_expected, w_expected_d;
  logic              r_err, w_err_d;
  logic [7:0]        r_err_count, w_err_count_d;

  logic [WIDTH-1:0]  w_pred;
  logic              w_is_inc;
  logic              w_is_dec;

  cc_step_predict #(
    .WIDTH (WIDTH),
    .INC   (INC),
    .DEC   (DEC)
  ) u_predict (
    .i_prev     (r_prev),
    .i_next_add (r_next_add),
    .i_sample   (i_count),
    .o_pred     (w_pred),
    .o_is_inc   (w_is_inc),
    .o_is_dec   (w_is_dec)
  );

  always_comb begin
    w_state_d     = r_state;
    w_prev_d      = r_prev;
    w_miss_d      = r_miss_run;
    w_next_add_d  = r_next_add;
    w_locked_d    = r_locked;
    w_err_d       = 1'b0;
    w_err_count_d = r_err_count;

    if (i_valid) begin
      w_prev_d = i_count;
      unique case (r_state)
        ST_IDLE: w_state_d = ST_SYNC;
        ST_SYNC: begin
          if (w_is_inc) begin
            w_next_add_d = 1'b0;
            w_locked_d   = 1'b1;
            w_state_d    = ST_LOCKED;
          end else if (w_is_dec) begin
            w_next_add_d = 1'b1;
            w_locked_d   = 1'b1;
            w_state_d    = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Phase follows the sample whether or not it matched.
          w_next_add_d = ~r_next_add;
          if (i_count == w_pred) begin
            w_miss_d = '0;
          end else begin
            w_err_d = 1'b1;
            if (r_err_count != 8'hFF) w_err_count_d = r_err_count + 8'd1;
            if (r_miss_run == MISS_W'(MISS_LIMIT - 1)) begin
              w_miss_d   = '0;
              w_locked_d = 1'b0;
              w_state_d  = ST_SYNC;
            end else begin
              w_miss_d = r_miss_run + MISS_W'(1);
            end
          end
        end
        default: w_state_d = ST_IDLE;
      endcase
    end

    w_expected_d = '0;
    if (w_locked_d) begin
      w_expected_d = w_next_add_d ? (w_prev_d + WIDTH'(INC)) : (w_prev_d - WIDTH'(DEC));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_miss_run  <= '0;
      r_next_add  <= 1'b0;
      r_locked    <= 1'b0;
      r_expected  <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_prev      <= w_prev_d;
      r_miss_run  <= w_miss_d;
      r_next_add  <= w_next_add_d;
      r_locked    <= w_locked_d;
      r_expected  <= w_expected_d;
      r_err       <= w_err_d;
      r_err_count <= w_err_count_d;
    end
  end

  assign o_locked    = r_locked;
  assign o_expected  = r_expected;
  assign o_next_add  = r_next_add;
  assign o_err       = r_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_custcounter_checker.sv
// Scoreboard bench for custcounter_checker: a reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_custcounter_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_count;
  logic       o_locked;
  logic [7:0] o_expected;
  logic       o_next_add;
  logic       o_err;
  logic [7:0] o_err_count;

  custcounter_checker #(
    .WIDTH      (8),
    .INC        (5),
    .DEC        (2),
    .MISS_LIMIT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_count     (i_count),
    .o_locked    (o_locked),
    .o_expected  (o_expected),
    .o_next_add  (o_next_add),
    .o_err       (o_err),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic [7:0] expected;
    logic       next_add;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;
  int checks = 0;
  int errors = 0;

  // Reference model: plain modulo-256 arithmetic over the stream rules.
  bit m_seen, m_locked, m_add, m_err;
  int m_prev, m_miss, m_cnt, m_exp;

  function automatic int m_pred();
    return m_add ? (m_prev + 5) % 256 : (m_prev + 254) % 256;
  endfunction

  function automatic void model_step(bit rst, bit v, int c);
    int d;
    m_err = 1'b0;
    if (rst) begin
      m_seen = 0; m_locked = 0; m_add = 0; m_prev = 0; m_miss = 0; m_cnt = 0;
    end else if (v) begin
      if (!m_seen) begin
        m_seen = 1;
      end else if (!m_locked) begin
        d = (c - m_prev + 256) % 256;
        if (d == 5) begin m_locked = 1; m_add = 0; end
        else if (d == 254) begin m_locked = 1; m_add = 1; end
      end else begin
        if (c == m_pred()) m_miss = 0;
        else begin
          m_err = 1;
          m_miss++;
          if (m_cnt < 255) m_cnt++;
        end
        m_add = !m_add;
        if (m_miss == 3) begin m_locked = 0; m_miss = 0; end
      end
      m_prev = c;
    end
    m_exp = m_locked ? m_pred() : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit v, input int c);
    reset   = rst;
    i_valid = v;
    i_count = c[7:0];
    @(posedge clk);
    model_step(rst, v, c);
    push_e.locked   = m_locked;
    push_e.expected = 8'(m_exp);
    push_e.next_add = m_add;
    push_e.err      = m_err;
    push_e.cnt      = 8'(m_cnt);
    sb.push_back(push_e);
    #1;
  endtask

  task automatic send_bad();
    drive(0, 1, (m_pred() + 1 + int'($urandom_range(0, 253))) % 256);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_locked", o_locked, mon_e.locked);
      chk("sb_expected", o_expected, mon_e.expected);
      chk("sb_err", o_err, mon_e.err);
      chk("sb_err_count", o_err_count, mon_e.cnt);
      if (mon_e.locked) chk("sb_next_add", o_next_add, mon_e.next_add);
    end
  end

  int s1[5] = '{0, 5, 3, 8, 6};
  int s2[5] = '{250, 255, 253, 2, 0};
  bit rv;

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_count = '0;
    drive(1, 0, 0);
    drive(1, 0, 0);
    chk("reset_locked", o_locked, 0);
    chk("reset_expected", o_expected, 0);
    chk("reset_err_count", o_err_count, 0);

    // 1: basic lock
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, s1[i]);
      if (i == 0) chk("s1_unlocked_first", o_locked, 0);
      if (i == 1) chk("s1_locked_after_5", o_locked, 1);
    end
    chk("s1_expected_11", o_expected, 11);
    chk("s1_no_err", o_err_count, 0);

    // 2: +5 wrap 253 -> 2; reset together with valid
    drive(1, 1, 77);
    for (int i = 0; i < 5; i++) drive(0, 1, s2[i]);
    chk("s2_expected_5", o_expected, 5);
    chk("s2_no_err", o_err_count, 0);
    // -2 wrap 1 -> 255
    drive(1, 0, 0);
    drive(0, 1, 252); drive(0, 1, 1); drive(0, 1, 255);
    chk("s2b_expected_4", o_expected, 4);
    chk("s2b_no_err", o_err_count, 0);

    // 3: single mismatch at prev=8, next add
    drive(1, 0, 0);
    drive(0, 1, 10); drive(0, 1, 8);
    chk("s3_next_add", o_next_add, 1);
    chk("s3_expected_13", o_expected, 13);
    drive(0, 1, 14);
    chk("s3_err_pulse", o_err, 1);
    chk("s3_err_count", o_err_count, 1);
    chk("s3_lock_kept", o_locked, 1);
    chk("s3_expected_12", o_expected, 12);
    drive(0, 0, 0);
    chk("s3_err_falls", o_err, 0);

    // 4: three misses drop lock, then relock on 7,12
    drive(0, 1, 12);
    drive(0, 1, 100); drive(0, 1, 0);
    chk("s4_still_locked", o_locked, 1);
    drive(0, 1, 50);
    chk("s4_unlocked", o_locked, 0);
    chk("s4_err_count", o_err_count, 4);
    drive(0, 1, 7);
    chk("s4_not_yet", o_locked, 0);
    drive(0, 1, 12);
    chk("s4_relocked", o_locked, 1);
    chk("s4_expected_10", o_expected, 10);

    // 5: idle cycles hold, then reset with valid
    for (int i = 0; i < 10; i++) drive(0, 0, int'($urandom_range(0, 255)));
    chk("s5_hold_expected", o_expected, 10);
    drive(0, 1, 10);
    chk("s5_expected_15", o_expected, 15);
    chk("s5_no_err", o_err, 0);
    drive(1, 1, 15);
    chk("s5_rst_locked", o_locked, 0);
    chk("s5_rst_expected", o_expected, 0);
    chk("s5_rst_next_add", o_next_add, 0);
    chk("s5_rst_err_count", o_err_count, 0);

    // 6: 260 mismatches, never three in a row
    drive(0, 1, 0); drive(0, 1, 5);
    for (int i = 0; i < 130; i++) begin
      send_bad();
      send_bad();
      drive(0, 1, m_pred());
    end
    chk("s6_saturated", o_err_count, 255);
    chk("s6_locked", o_locked, 1);

    // Random stream: mostly correct samples, gaps, stray values, rare resets
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) drive(1, rv, int'($urandom_range(0, 255)));
      else if (m_locked && $urandom_range(0, 7) != 0) drive(0, rv, m_pred());
      else drive(0, rv, int'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
